// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: runs the load/store handshake to a multi-cycle data
// memory, stalls upstream while an access is outstanding, and delivers one write-back result per instruction.
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_mem_rd,
  input  logic        ex_mem_wr,
  input  logic [15:0] ex_result,
  input  logic [15:0] ex_wdata,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  input  logic        mem_err,
  output logic        stall,
  output logic        wb_valid,
  output logic [15:0] wb_data,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        op_wr, op_wr_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [15:0] addr_nxt, wdata_nxt, wb_data_nxt;
  logic        wb_valid_nxt, err_nxt;
  logic        is_mem;

  assign is_mem = ex_mem_rd | ex_mem_wr;

  // Strobes decode straight from the registered state, so they last exactly the REQ cycle.
  assign mem_rd = (state == REQ) && !op_wr;
  assign mem_wr = (state == REQ) && op_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_wr     <= 1'b0;
      cnt       <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wb_data   <= '0;
      wb_valid  <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      op_wr     <= op_wr_nxt;
      cnt       <= cnt_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
      wb_data   <= wb_data_nxt;
      wb_valid  <= wb_valid_nxt;
      err       <= err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    op_wr_nxt    = op_wr;
    cnt_nxt      = cnt;
    addr_nxt     = mem_addr;
    wdata_nxt    = mem_wdata;
    wb_data_nxt  = wb_data;
    wb_valid_nxt = 1'b0;
    err_nxt      = err;
    stall        = 1'b0;

    case (state)
      IDLE: begin
        if (ex_valid) begin
          if (!is_mem) begin
            wb_valid_nxt = 1'b1;
            wb_data_nxt  = ex_result;
          end else if (ex_result[0]) begin
            err_nxt      = 1'b1;
            wb_valid_nxt = 1'b1;
            wb_data_nxt  = '0;
          end else begin
            addr_nxt  = ex_result;
            wdata_nxt = ex_wdata;
            op_wr_nxt = ex_mem_wr;
            stall     = 1'b1;
            state_nxt = REQ;
          end
        end
      end

      REQ, WAIT: begin
        stall = 1'b1;
        if (state == REQ) cnt_nxt = '0;
        else              cnt_nxt = cnt + 8'd1;
        // mem_done takes priority over the timeout when both land in the same cycle.
        if (mem_done) begin
          state_nxt    = DONE;
          wb_valid_nxt = 1'b1;
          wb_data_nxt  = op_wr ? '0 : mem_rdata;
          if (mem_err) err_nxt = 1'b1;
        end else if (state == REQ) begin
          state_nxt = WAIT;
        end else if (cnt == TO_LAST) begin
          state_nxt    = DONE;
          wb_valid_nxt = 1'b1;
          wb_data_nxt  = '0;
          err_nxt      = 1'b1;
        end
      end

      DONE: state_nxt = IDLE;

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl with TIMEOUT=4: pass-through, load, store,
// both-strobe op, misaligned access, timeout edge and reset mid-access.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_mem_rd, ex_mem_wr;
  logic [15:0] ex_result, ex_wdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr, mem_done, mem_err;
  logic        stall, wb_valid, err;
  logic [15:0] wb_data;

  int unsigned checks = 0;
  int unsigned errors = 0;

  mem_stage_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
    .ex_result(ex_result), .ex_wdata(ex_wdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_err(mem_err),
    .stall(stall), .wb_valid(wb_valid), .wb_data(wb_data), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [15:0] res, input logic [15:0] wd);
    ex_valid  = 1'b1;
    ex_mem_rd = rd;
    ex_mem_wr = wr;
    ex_result = res;
    ex_wdata  = wd;
    #1;
  endtask

  task automatic idle_in();
    ex_valid  = 1'b0;
    ex_mem_rd = 1'b0;
    ex_mem_wr = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_mem_rd = 1'b0; ex_mem_wr = 1'b0;
    ex_result = '0; ex_wdata = '0; mem_rdata = '0; mem_done = 1'b0; mem_err = 1'b0;
    tick(); tick();
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_err", err, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_stall", stall, 0);
    rst = 1'b0;

    // Non-memory pass-through
    issue(0, 0, 16'h1234, 16'h0);
    check("nm_stall", stall, 0);
    tick(); idle_in();
    check("nm_wb_valid", wb_valid, 1);
    check("nm_wb_data", wb_data, 16'h1234);
    check("nm_stall2", stall, 0);
    check("nm_err", err, 0);
    tick();
    check("nm_wb_pulse", wb_valid, 0);

    // Load, done two cycles after REQ
    issue(1, 0, 16'h0040, 16'h0);
    check("ld_acc_stall", stall, 1);
    tick(); idle_in();
    check("ld_req_rd", mem_rd, 1);
    check("ld_req_wr", mem_wr, 0);
    check("ld_req_addr", mem_addr, 16'h0040);
    check("ld_req_stall", stall, 1);
    check("ld_req_wbv", wb_valid, 0);
    tick();
    check("ld_w0_rd", mem_rd, 0);
    check("ld_w0_stall", stall, 1);
    tick();
    mem_done = 1'b1; mem_rdata = 16'hBEEF;
    check("ld_w1_rd", mem_rd, 0);
    check("ld_w1_stall", stall, 1);
    tick();
    mem_done = 1'b0; mem_rdata = '0; #1;
    check("ld_done_wbv", wb_valid, 1);
    check("ld_done_data", wb_data, 16'hBEEF);
    check("ld_done_stall", stall, 0);
    check("ld_done_err", err, 0);
    tick();
    check("ld_idle_wbv", wb_valid, 0);

    // Store completing in REQ: accept, REQ, DONE
    issue(0, 1, 16'h0010, 16'hA5A5);
    check("st_acc_stall", stall, 1);
    tick(); idle_in();
    mem_done = 1'b1;
    check("st_req_wr", mem_wr, 1);
    check("st_req_rd", mem_rd, 0);
    check("st_req_wdata", mem_wdata, 16'hA5A5);
    check("st_req_addr", mem_addr, 16'h0010);
    tick();
    mem_done = 1'b0; #1;
    check("st_done_wbv", wb_valid, 1);
    check("st_done_data", wb_data, 16'h0000);
    check("st_done_wr", mem_wr, 0);
    check("st_done_stall", stall, 0);
    tick();

    // rd and wr both set is a store
    issue(1, 1, 16'h0020, 16'h1111);
    tick(); idle_in();
    mem_done = 1'b1; mem_rdata = 16'h7777;
    check("both_wr", mem_wr, 1);
    check("both_rd", mem_rd, 0);
    tick();
    mem_done = 1'b0; #1;
    check("both_data", wb_data, 16'h0000);
    tick();

    // mem_done in the last WAIT cycle beats the timeout
    issue(1, 0, 16'h0080, 16'h0);
    tick(); idle_in();
    check("tl_req_rd", mem_rd, 1);
    tick(); tick(); tick(); tick();
    mem_done = 1'b1; mem_rdata = 16'h5A5A;
    check("tl_w3_stall", stall, 1);
    tick();
    mem_done = 1'b0; mem_rdata = 16'hFFFF; #1;
    check("tl_done_wbv", wb_valid, 1);
    check("tl_done_err", err, 0);
    check("tl_done_data", wb_data, 16'h5A5A);
    tick();

    // Timeout: four WAIT cycles with no mem_done
    issue(1, 0, 16'h0084, 16'h0);
    tick(); idle_in();
    tick(); tick(); tick(); tick();
    check("to_w3_stall", stall, 1);
    check("to_w3_wbv", wb_valid, 0);
    check("to_w3_err", err, 0);
    tick();
    check("to_done_wbv", wb_valid, 1);
    check("to_done_err", err, 1);
    check("to_done_data", wb_data, 16'h0000);
    check("to_done_stall", stall, 0);
    tick();

    rst = 1'b1; tick(); rst = 1'b0;
    check("rst2_err", err, 0);

    // Misaligned load never reaches memory
    issue(1, 0, 16'h0041, 16'h0);
    check("mis_stall", stall, 0);
    tick(); idle_in();
    check("mis_rd", mem_rd, 0);
    check("mis_err", err, 1);
    check("mis_wbv", wb_valid, 1);
    check("mis_data", wb_data, 16'h0000);
    tick();
    check("mis_rd2", mem_rd, 0);
    for (int i = 0; i < 5; i++) begin
      issue(0, 0, 16'h0100 + 16'(i), 16'h0);
      tick();
      check("sticky_wbv", wb_valid, 1);
      check("sticky_data", wb_data, 16'h0100 + 16'(i));
      check("sticky_err", err, 1);
    end
    idle_in();

    // Reset while in WAIT, then a late mem_done
    issue(1, 0, 16'h0200, 16'h0);
    tick(); idle_in();
    tick();
    check("rm_w_stall", stall, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    check("rm_rd", mem_rd, 0);
    check("rm_wr", mem_wr, 0);
    check("rm_stall", stall, 0);
    check("rm_wbv", wb_valid, 0);
    check("rm_err", err, 0);
    mem_done = 1'b1; mem_rdata = 16'hDEAD;
    tick();
    mem_done = 1'b0; #1;
    check("late_wbv", wb_valid, 0);
    check("late_stall", stall, 0);
    check("late_data", wb_data, 16'h0000);
    tick();
    check("late_wbv2", wb_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory-stage controller that consumes the execute stage's outputs (ALU result as address or pass-through value, second register operand as store data) and runs the load/store handshake toward a multi-cycle data memory or cache.
- Holds the pipeline with a stall while an access is outstanding.
- Delivers one result per instruction to the write-back side and flags misaligned, errored or timed-out accesses.

Parameters:
- TIMEOUT, 16, maximum WAIT cycles without mem_done before an error is declared (range 2..255).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ex_valid  in  1  execute-stage result valid this cycle
- ex_mem_rd  in  1  instruction is a load
- ex_mem_wr  in  1  instruction is a store
- ex_result  in  16  ALU result: address for loads/stores, write-back value otherwise
- ex_wdata  in  16  store data (second register operand)
- mem_addr  out  16  memory address (registered)
- mem_wdata  out  16  memory write data (registered)
- mem_rd  out  1  read request strobe
- mem_wr  out  1  write request strobe
- mem_rdata  in  16  memory read data, valid when mem_done=1
- mem_done  in  1  memory access complete
- mem_err  in  1  memory fault, sampled only with mem_done
- stall  out  1  hold upstream pipeline (combinational)
- wb_valid  out  1  wb_data valid, one-cycle pulse per instruction
- wb_data  out  16  load data or passed-through ALU result
- err  out  1  sticky error flag

Behaviour:
- Reset (clk edge with rst=1):
  - state is IDLE.
  - mem_rd, mem_wr, wb_valid and err are 0.
  - mem_addr, mem_wdata and wb_data are 0x0000.
  - Reset wins over every other event, including an access in flight; the strobes are 0 from the next cycle.
- States: IDLE, REQ, WAIT, DONE.
- IDLE, ex_valid=1, neither ex_mem_rd nor ex_mem_wr:
  - Next cycle: wb_valid=1 and wb_data=ex_result (one-cycle pass-through latency).
  - State stays IDLE; stall=0.
- IDLE, ex_valid=1, ex_mem_rd or ex_mem_wr, and ex_result[0]=1 (misaligned):
  - No memory request is issued.
  - Next cycle: err=1, wb_valid=1, wb_data=0x0000.
  - State stays IDLE.
- IDLE, ex_valid=1, aligned access (accept):
  - Capture mem_addr=ex_result, mem_wdata=ex_wdata, and the op type.
  - stall=1 combinationally in the accept cycle.
  - Next state is REQ.
- ex_mem_rd and ex_mem_wr both 1: treated as a store.
- REQ:
  - Exactly one cycle; mem_rd or mem_wr is 1 for this cycle only.
  - stall=1.
  - mem_done=1 in this cycle goes to DONE; otherwise go to WAIT and clear the timeout counter.
- WAIT:
  - Strobes 0; stall=1; the 8-bit counter increments each cycle.
  - mem_done=1 goes to DONE.
  - Counter reaching TIMEOUT-1 without mem_done: err=1, wb_data=0x0000, go to DONE.
  - mem_done arriving in the same cycle as the timeout: done wins.
- On the transition into DONE by mem_done:
  - wb_data is captured as mem_rdata for loads and 0x0000 for stores.
  - mem_err=1 sets err.
- DONE:
  - wb_valid=1 for this cycle; stall=0; next state is IDLE.
  - New ex_valid is ignored in DONE; upstream holds its instruction because stall was 1 in the preceding cycle and re-presents it in IDLE.
- mem_done outside REQ/WAIT: ignored.
- err is sticky until reset.
- wb_valid=0 in every state and cycle not listed above.
- Throughput:
  - Non-memory instructions: one per cycle.
  - Memory access: minimum 3 cycles (accept, REQ with done, DONE).

Test Plan:
- Reset then non-memory op: ex_valid=1, rd=wr=0, ex_result=0x1234 -> next cycle wb_valid=1, wb_data=0x1234; stall=0 throughout; err=0.
- Load: ex_result=0x0040, mem_done=1 with mem_rdata=0xBEEF two cycles after REQ -> mem_rd high exactly one cycle with mem_addr=0x0040; stall high accept..WAIT; DONE wb_valid=1, wb_data=0xBEEF.
- Store: ex_result=0x0010, ex_wdata=0xA5A5, mem_done in REQ cycle -> mem_wr one cycle with mem_wdata=0xA5A5; wb_valid pulse in next cycle, wb_data=0x0000; total 3 cycles.
- Misaligned load: ex_result=0x0041 -> no mem_rd ever; next cycle err=1, wb_valid=1; err stays 1 across the next 5 non-memory ops.
- Timeout: TIMEOUT=4, load, mem_done held 0 -> DONE entered after 4 WAIT cycles with err=1, wb_data=0x0000. Repeat with mem_done in the final WAIT cycle -> err=0, data captured.
- Reset mid-access: assert rst while in WAIT -> next cycle state IDLE, mem_rd=mem_wr=0, stall=0, wb_valid=0, err=0. A late mem_done after reset is ignored.
